// File: rtl/voice_mixer_if.sv
// Bus bundle between the voice array / gain control side and the stereo mixer.
// The master modport drives samples and gain writes; the slave modport is the mixer.
interface voice_mixer_if #(
    parameter int NUM_VOICES = 6,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [NUM_VOICES*SAMPLE_W-1:0] voices_in;
    logic                           sample_ready;
    logic                           gain_we;
    logic [IDX_W-1:0]               gain_addr;
    logic                           gain_ch;
    logic [GAIN_W-1:0]              gain_data;
    logic [SAMPLE_W-1:0]            mix_left;
    logic [SAMPLE_W-1:0]            mix_right;
    logic                           mix_valid;
    logic                           clip_left;
    logic                           clip_right;
    logic                           busy;
    logic                           overrun;

    modport master (
        output voices_in, sample_ready, gain_we, gain_addr, gain_ch, gain_data,
        input  mix_left, mix_right, mix_valid, clip_left, clip_right, busy, overrun
    );

    modport slave (
        input  voices_in, sample_ready, gain_we, gain_addr, gain_ch, gain_data,
        output mix_left, mix_right, mix_valid, clip_left, clip_right, busy, overrun
    );
endinterface

// File: rtl/voice_mixer.sv
// Stereo voice mixer: snapshots all voices on sample_ready, multiply-accumulates
// one voice per cycle against double-buffered L/R gains, emits a saturated pair.
module voice_mixer #(
    parameter int NUM_VOICES = 6,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
) (
    input  logic            clk37,
    input  logic            rst_n,
    voice_mixer_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + GAIN_W + 1 + IDX_W;

    localparam logic [GAIN_W-1:0]       GAIN_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_VOICES - 1);
    localparam logic [IDX_W:0]          NV_EXT     = (IDX_W+1)'(NUM_VOICES);
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      next_state_s;
    logic signed [SAMPLE_W-1:0]  snap_r      [NUM_VOICES];
    logic [GAIN_W-1:0]           gain_sh_l_r [NUM_VOICES];
    logic [GAIN_W-1:0]           gain_sh_r_r [NUM_VOICES];
    logic [GAIN_W-1:0]           gain_act_l_r[NUM_VOICES];
    logic [GAIN_W-1:0]           gain_act_r_r[NUM_VOICES];
    logic signed [ACC_W-1:0]     acc_l_r;
    logic signed [ACC_W-1:0]     acc_r_r;
    logic [IDX_W-1:0]            idx_r;
    logic signed [ACC_W-1:0]     prod_l_s;
    logic signed [ACC_W-1:0]     prod_r_s;
    logic [SAMPLE_W:0]           sat_l_s;
    logic [SAMPLE_W:0]           sat_r_s;
    logic [SAMPLE_W-1:0]         mix_left_r;
    logic [SAMPLE_W-1:0]         mix_right_r;
    logic                        mix_valid_r;
    logic                        clip_left_r;
    logic                        clip_right_r;
    logic                        busy_r;
    logic                        overrun_r;

    // Floor-shift back to sample scale, then clamp; returns {clipped, value}.
    function automatic logic [SAMPLE_W:0] sat_fn(input logic signed [ACC_W-1:0] acc_v);
        logic signed [ACC_W-1:0] sh_v;
        sh_v = acc_v >>> (GAIN_W - 1);
        if (sh_v > SAT_MAX) begin
            return {1'b1, SAT_MAX[SAMPLE_W-1:0]};
        end else if (sh_v < SAT_MIN) begin
            return {1'b1, SAT_MIN[SAMPLE_W-1:0]};
        end else begin
            return {1'b0, sh_v[SAMPLE_W-1:0]};
        end
    endfunction

    // State register.
    always_ff @(posedge clk37 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; strobes outside IDLE never restart a frame.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.sample_ready) begin
                    next_state_s = ST_ACCUM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (idx_r == IDX_LAST) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_ACCUM;
                end
            end
            ST_FINISH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Signed sample times zero-extended gain, widened before the add.
    always_comb begin
        prod_l_s = ACC_W'(snap_r[idx_r] * $signed({1'b0, gain_act_l_r[idx_r]}));
        prod_r_s = ACC_W'(snap_r[idx_r] * $signed({1'b0, gain_act_r_r[idx_r]}));
        sat_l_s  = sat_fn(acc_l_r);
        sat_r_s  = sat_fn(acc_r_r);
    end

    // Shadow gain bank; writes land in any state, out-of-range indices dropped.
    always_ff @(posedge clk37 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                gain_sh_l_r[k] <= GAIN_UNITY;
                gain_sh_r_r[k] <= GAIN_UNITY;
            end
        end else if (bus.gain_we && ({1'b0, bus.gain_addr} < NV_EXT)) begin
            if (bus.gain_ch) begin
                gain_sh_r_r[bus.gain_addr] <= bus.gain_data;
            end else begin
                gain_sh_l_r[bus.gain_addr] <= bus.gain_data;
            end
        end
    end

    // Snapshot, accumulate and finish datapath.
    always_ff @(posedge clk37 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                snap_r[k]       <= '0;
                gain_act_l_r[k] <= GAIN_UNITY;
                gain_act_r_r[k] <= GAIN_UNITY;
            end
            acc_l_r      <= '0;
            acc_r_r      <= '0;
            idx_r        <= '0;
            mix_left_r   <= '0;
            mix_right_r  <= '0;
            clip_left_r  <= 1'b0;
            clip_right_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.sample_ready) begin
                        for (int k = 0; k < NUM_VOICES; k++) begin
                            snap_r[k] <= $signed(bus.voices_in[k*SAMPLE_W +: SAMPLE_W]);
                        end
                        gain_act_l_r <= gain_sh_l_r;
                        gain_act_r_r <= gain_sh_r_r;
                        acc_l_r      <= '0;
                        acc_r_r      <= '0;
                        idx_r        <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc_l_r <= acc_l_r + prod_l_s;
                    acc_r_r <= acc_r_r + prod_r_s;
                    idx_r   <= idx_r + IDX_W'(1);
                end
                ST_FINISH: begin
                    mix_left_r   <= sat_l_s[SAMPLE_W-1:0];
                    mix_right_r  <= sat_r_s[SAMPLE_W-1:0];
                    clip_left_r  <= sat_l_s[SAMPLE_W];
                    clip_right_r <= sat_r_s[SAMPLE_W];
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    // Status strobes; busy tracks the state the FSM is entering.
    always_ff @(posedge clk37 or negedge rst_n) begin
        if (!rst_n) begin
            mix_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            mix_valid_r <= (state_r == ST_FINISH);
            busy_r      <= (next_state_s != ST_IDLE);
            if (bus.sample_ready && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign bus.mix_left   = mix_left_r;
    assign bus.mix_right  = mix_right_r;
    assign bus.mix_valid  = mix_valid_r;
    assign bus.clip_left  = clip_left_r;
    assign bus.clip_right = clip_right_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
Parametrised stereo mixer between the voice array and the I2S output-word register, in the clk37 domain. On each sample_ready strobe it snapshots NUM_VOICES signed voice samples. It then multiply-accumulates them one voice per cycle against per-voice left and right gains, and emits a saturated stereo pair with a one-cycle valid strobe. It adds double-buffered gains, saturation with clip flags, and overrun detection.

Parameters:
NUM_VOICES, 6, number of voice inputs (>=2)
SAMPLE_W, 16, signed width of voice samples and mix outputs
GAIN_W, 8, unsigned gain width; unity gain = 2^(GAIN_W-1)
IDX_W, $clog2(NUM_VOICES), voice index width (derived, not overridden)
ACC_W, SAMPLE_W+GAIN_W+1+IDX_W, signed accumulator width (derived)

Ports:
clk37  in  1  synth clock
rst_n  in  1  asynchronous active-low reset
voices_in  in  NUM_VOICES*SAMPLE_W  packed signed samples; voice k occupies bits [k*SAMPLE_W +: SAMPLE_W]
sample_ready  in  1  one-cycle frame strobe from voice 0
gain_we  in  1  gain shadow write enable
gain_addr  in  IDX_W  voice index for the write
gain_ch  in  1  0 = left gain, 1 = right gain
gain_data  in  GAIN_W  unsigned gain value
mix_left  out  SAMPLE_W  signed left mix, held between frames
mix_right  out  SAMPLE_W  signed right mix, held between frames
mix_valid  out  1  one-cycle strobe; mix_left/mix_right updated this cycle
clip_left  out  1  left mix saturated this frame; valid with mix_valid, held until the next frame
clip_right  out  1  right mix saturated this frame; same timing as clip_left
busy  out  1  high in ACCUM and FINISH
overrun  out  1  sticky; sample_ready arrived while busy

Behaviour:
- Reset (async assert, sync release): state IDLE. mix_left, mix_right, mix_valid, clip_*, busy and overrun are all 0. Shadow and active gains are 2^(GAIN_W-1). Accumulators and index are 0.
- Gain write: when gain_we=1 and gain_addr<NUM_VOICES, write gain_data to shadow[gain_addr][gain_ch] at the clock edge. An out-of-range gain_addr is ignored. Writes are accepted in any state.
- Active gains are loaded from the shadow gains only at snapshot. A write in the same cycle as the snapshot is not included; it applies from the next frame.
- States: IDLE, ACCUM, FINISH.
- IDLE, sample_ready=1 at edge E0:
  - latch all voices_in into the snapshot registers;
  - copy shadow gains to active gains;
  - clear acc_l, acc_r and idx;
  - go to ACCUM.
- ACCUM, edges E1..E(NUM_VOICES): acc_l += snap[idx]*gain_l[idx] and acc_r += snap[idx]*gain_r[idx]. The products are signed SAMPLE_W times zero-extended GAIN_W, accumulated at ACC_W with no intermediate overflow. idx increments each edge. On the edge that processes idx=NUM_VOICES-1, go to FINISH.
- FINISH, edge E(NUM_VOICES+1):
  - arithmetic-shift each accumulator right by GAIN_W-1 (floor);
  - saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1];
  - register mix_left/mix_right, set clip_* if saturation occurred, pulse mix_valid=1;
  - go to IDLE.
- Latency: mix_valid is high in the cycle after edge E(NUM_VOICES+1); for the default that is 7 edges after the sample_ready edge. mix_valid is never high for two consecutive cycles.
- busy=1 exactly while the state is ACCUM or FINISH.
- sample_ready while the state is not IDLE: the strobe is ignored and the frame in progress is unaffected. overrun is set and stays set until reset.
- sample_ready in IDLE in the same cycle that mix_valid is high: the new frame is accepted normally; the FINISH→IDLE transition has already completed.
- voices_in changing after E0 has no effect on the frame in progress.
- Reset asserted mid-ACCUM: immediate return to reset values, no mix_valid. The next frame starts cleanly after release.
- Outputs hold their last value until the next FINISH.

Test Plan:
- Default gains (128), all voices = 1000, one sample_ready → mix_valid 7 cycles later; mix_left = mix_right = 6000; clip_* = 0.
- All voices = 32767, all gains = 255 → mix_left = mix_right = 32767, clip_left = clip_right = 1. Then all voices = -32768 → outputs -32768, clip flags 1.
- Voice 2 = -1, all others 0, gains unity → outputs -1. Then gain_l[2] = 0 → mix_left = 0, mix_right = -1.
- Write gain_r[0] = 0 while busy (voice 0 = 500, others 0, unity gains) → current frame mix_right = 500; next frame mix_right = 0. A write with gain_addr = 7 (out of range) → no gain changes.
- sample_ready pulsed 3 cycles after a frame start → exactly one mix_valid, overrun = 1 and still 1 after 100 idle cycles.
- rst_n low for 1 cycle during ACCUM → no mix_valid, outputs 0, overrun 0. The next frame with all voices = 100 → outputs 600.
